// File: rtl/ex_hazard_unit_pkg.sv
// ============================================================================
// ex_hazard_unit_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the execute-stage hazard / forwarding controller:
//   - fwd_sel_e   : operand forward-select encodings (register file, memory
//                   stage, writeback stage)
//   - hz_state_e  : hazard FSM states (RUN, FLUSH)
//   - NOP_INSTR   : canonical NOP (addi x0, x0, 0) loaded on a fetch flush
//   - REG_W / *_LSB : register index width and instruction field positions
// ============================================================================
package ex_hazard_unit_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } hz_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS2_LSB = 20;

endpackage

// File: rtl/ex_hazard_unit_hazard_fwd_sel.sv
// ============================================================================
// hazard_fwd_sel
// ----------------------------------------------------------------------------
// Combinational forward select for one execute-stage source operand.
// The memory stage has priority over writeback because it holds the younger
// result. x0 is never a forwarding source.
//
// Ports:
//   rs            in   REG_W  source register index of the execute instruction
//   mem_rd        in   REG_W  destination held in the memory-stage shadow
//   mem_regwrite  in   1      memory-stage instruction writes mem_rd
//   wb_rd         in   REG_W  destination held in the writeback-stage shadow
//   wb_regwrite   in   1      writeback-stage instruction writes wb_rd
//   sel           out  2      FWD_RF / FWD_MEM / FWD_WB
// ============================================================================
module hazard_fwd_sel
    import ex_hazard_unit_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_regwrite,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_regwrite,
    output fwd_sel_e         sel
);

    always_comb begin
        sel = FWD_RF;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == rs)) begin
            sel = FWD_MEM;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/ex_hazard_unit.sv
// ============================================================================
// ex_hazard_unit
// ----------------------------------------------------------------------------
// Hazard and forwarding controller sitting at the consuming end of the
// decode-to-execute pipeline register. It keeps a private shadow of the
// memory- and writeback-stage destinations, so later pipeline registers do
// not need extra fields.
//
// Build option (macro HAZARD_FWD_EN):
//   defined   : operand forwarding from memory/writeback; only load-use
//               hazards stall.
//   undefined : no forwarding (fwd_a = fwd_b = 00); full interlock stalls
//               while any pending writer (ex, mem, wb) targets a decode source.
//
// Parameters:
//   FLUSH_DEPTH  squash cycles after a taken branch, counting the resolving
//                cycle (1..3)
//   CNT_W        width of the saturating stall counter
//
// Ports:
//   clk              in   1      pipeline clock, rising edge
//   reset            in   1      asynchronous, active-high; clears all state
//                                and forces all control outputs low
//   id_idata         in   32     instruction in decode (rs1/rs2 used)
//   ex_idata         in   32     instruction in execute (rd, rs1, rs2 used)
//   ex_regwrite      in   1      execute instruction writes rd
//   ex_memtoreg      in   1      execute instruction is a load
//   ex_branch_taken  in   1      branch/jump resolved taken in execute
//   pc_hold          out  1      PC keeps its value
//   ifid_hold        out  1      fetch/decode register keeps its value
//   ifid_flush       out  1      fetch/decode register loads NOP_INSTR
//   idex_bubble      out  1      decode/execute control inputs forced to 0
//   fwd_a, fwd_b     out  2      operand select (00 RF, 01 MEM, 10 WB)
//   stall_count      out  CNT_W  saturating count of stall cycles
// ============================================================================
module ex_hazard_unit
    import ex_hazard_unit_pkg::*;
#(
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      id_idata,
    input  logic [31:0]      ex_idata,
    input  logic             ex_regwrite,
    input  logic             ex_memtoreg,
    input  logic             ex_branch_taken,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_count
);

    // Value loaded into the counter on entering FLUSH.
    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_DEPTH - 1);

    // ------------------------------------------------------------------
    // Instruction field extraction
    // ------------------------------------------------------------------
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic [REG_W-1:0] ex_rd;

    assign id_rs1 = id_idata[RS1_LSB +: REG_W];
    assign id_rs2 = id_idata[RS2_LSB +: REG_W];
    assign ex_rd  = ex_idata[RD_LSB  +: REG_W];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    hz_state_e        state_q;
    hz_state_e        state_d;
    logic [1:0]       flush_cnt_q;
    logic [1:0]       flush_cnt_d;

    logic [REG_W-1:0] mem_rd;
    logic             mem_regwrite;
    logic             mem_memtoreg;
    logic [REG_W-1:0] wb_rd;
    logic             wb_regwrite;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic     ex_hit;
    logic     hazard;
    logic     flush_active;
    logic     stall;
    fwd_sel_e fwd_a_sel;
    fwd_sel_e fwd_b_sel;

    assign ex_hit = ex_regwrite && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

`ifdef HAZARD_FWD_EN
    logic [REG_W-1:0] ex_rs1;
    logic [REG_W-1:0] ex_rs2;

    assign ex_rs1 = ex_idata[RS1_LSB +: REG_W];
    assign ex_rs2 = ex_idata[RS2_LSB +: REG_W];

    // With forwarding, only a load in execute cannot be bypassed in time.
    assign hazard = ex_hit && ex_memtoreg;

    hazard_fwd_sel u_fwd_a (
        .rs           (ex_rs1),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .sel          (fwd_a_sel)
    );

    hazard_fwd_sel u_fwd_b (
        .rs           (ex_rs2),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .sel          (fwd_b_sel)
    );
`else
    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_regwrite && (mem_rd != '0) &&
                     ((mem_rd == id_rs1) || (mem_rd == id_rs2));
    assign wb_hit  = wb_regwrite && (wb_rd != '0) &&
                     ((wb_rd == id_rs1) || (wb_rd == id_rs2));

    // Without forwarding, decode waits until every pending writer retires.
    assign hazard = ex_hit || mem_hit || wb_hit;

    assign fwd_a_sel = FWD_RF;
    assign fwd_b_sel = FWD_RF;
`endif

    // Flush takes priority: a taken branch (or an ongoing squash) means the
    // decode instruction is wrong-path, so stalling it would be pointless.
    assign flush_active = (state_q == ST_FLUSH) || ex_branch_taken;
    assign stall        = (state_q == ST_RUN) && !ex_branch_taken && hazard;

    // Bits not consumed by the selected configuration.
    logic unused_bits;
    assign unused_bits = ^{id_idata, ex_idata, ex_memtoreg, mem_memtoreg};

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (ex_branch_taken && (FLUSH_DEPTH > 1)) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_INIT;
                end
            end
            ST_FLUSH: begin
                // Branches seen here are ignored: execute holds a bubble.
                // Leave once the decremented count reaches zero.
                flush_cnt_d = flush_cnt_q - 2'd1;
                if (flush_cnt_q <= 2'd1) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d     = ST_RUN;
                flush_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control outputs (forced low while reset is asserted)
    // ------------------------------------------------------------------
    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        fwd_a       = FWD_RF;
        fwd_b       = FWD_RF;
        if (!reset) begin
            pc_hold     = stall;
            ifid_hold   = stall;
            ifid_flush  = flush_active;
            idex_bubble = stall || flush_active;
            fwd_a       = fwd_a_sel;
            fwd_b       = fwd_b_sel;
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            flush_cnt_q  <= '0;
            mem_rd       <= '0;
            mem_regwrite <= 1'b0;
            mem_memtoreg <= 1'b0;
            wb_rd        <= '0;
            wb_regwrite  <= 1'b0;
            stall_count  <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            // Execute always advances (bubbles included), so the shadow
            // shifts unconditionally.
            mem_rd       <= ex_rd;
            mem_regwrite <= ex_regwrite;
            mem_memtoreg <= ex_memtoreg;
            wb_rd        <= mem_rd;
            wb_regwrite  <= mem_regwrite;
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ex_hazard_unit.sv
module tb_ex_hazard_unit;
    import ex_hazard_unit_pkg::*;

    localparam int unsigned FLUSH_DEPTH = 2;
    localparam int unsigned CNT_W       = 4;
    localparam int          CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      id_idata;
    logic [31:0]      ex_idata;
    logic             ex_regwrite;
    logic             ex_memtoreg;
    logic             ex_branch_taken;
    logic             pc_hold;
    logic             ifid_hold;
    logic             ifid_flush;
    logic             idex_bubble;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_count;
    logic [7:0]       ctl_vec;

    int n_cmp = 0;
    int n_bad = 0;

    assign ctl_vec = {pc_hold, ifid_hold, ifid_flush, idex_bubble, fwd_a, fwd_b};

    always #5 clk = ~clk;

    ex_hazard_unit #(
        .FLUSH_DEPTH (FLUSH_DEPTH),
        .CNT_W       (CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_idata        (id_idata),
        .ex_idata        (ex_idata),
        .ex_regwrite     (ex_regwrite),
        .ex_memtoreg     (ex_memtoreg),
        .ex_branch_taken (ex_branch_taken),
        .pc_hold         (pc_hold),
        .ifid_hold       (ifid_hold),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .stall_count     (stall_count)
    );

    // ---------------- instruction encoders / field decoders ----------------
    function automatic logic [31:0] enc_r(input int rd, input int rs1, input int rs2);
        return 32'((rs2 << 20) | (rs1 << 15) | (rd << 7) | 32'h33);
    endfunction

    function automatic logic [31:0] enc_lw(input int rd, input int rs1);
        return 32'((rs1 << 15) | (2 << 12) | (rd << 7) | 32'h03);
    endfunction

    function automatic int fld(input logic [31:0] x, input int lsb);
        return int'((x >> lsb) & 32'h1f);
    endfunction

    // ---------------- reference model ----------------
    int m_flush_left;   // FLUSH cycles still owed after the current one
    int m_rd[3];        // [1] = one cycle ago in execute, [2] = two cycles ago
    bit m_wr[3];
    int m_cnt;

    function automatic bit writes(input bit en, input int rd, input int s1, input int s2);
        return en && (rd != 0) && ((rd == s1) || (rd == s2));
    endfunction

    function automatic bit m_hazard();
        int s1   = fld(id_idata, 15);
        int s2   = fld(id_idata, 20);
        int exrd = fld(ex_idata, 7);
`ifdef HAZARD_FWD_EN
        return ex_memtoreg && writes(ex_regwrite, exrd, s1, s2);
`else
        return writes(ex_regwrite, exrd, s1, s2) ||
               writes(m_wr[1], m_rd[1], s1, s2) ||
               writes(m_wr[2], m_rd[2], s1, s2);
`endif
    endfunction

    function automatic int m_fwd(input int rs);
`ifdef HAZARD_FWD_EN
        if (writes(m_wr[1], m_rd[1], rs, rs)) return 1;
        if (writes(m_wr[2], m_rd[2], rs, rs)) return 2;
`endif
        return rs * 0;
    endfunction

    function automatic bit m_flushing();
        return (m_flush_left > 0) || ex_branch_taken;
    endfunction

    function automatic logic [7:0] m_ctl();
        bit fl = m_flushing();
        bit st = !fl && m_hazard();
        int fa = m_fwd(fld(ex_idata, 15));
        int fb = m_fwd(fld(ex_idata, 20));
        return {st, st, fl, st | fl, 2'(fa), 2'(fb)};
    endfunction

    task automatic m_reset();
        m_flush_left = 0;
        m_cnt        = 0;
        for (int i = 0; i < 3; i++) begin
            m_rd[i] = 0;
            m_wr[i] = 1'b0;
        end
    endtask

    task automatic m_step();
        bit st = !m_flushing() && m_hazard();
        if (st && m_cnt < CNT_MAX) m_cnt++;
        if (m_flush_left > 0) m_flush_left--;
        else if (ex_branch_taken) m_flush_left = FLUSH_DEPTH - 1;
        m_rd[2] = m_rd[1];
        m_wr[2] = m_wr[1];
        m_rd[1] = fld(ex_idata, 7);
        m_wr[1] = ex_regwrite;
    endtask

    // ---------------- bench helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [31:0] id, input logic [31:0] ex,
                         input logic rw, input logic mtr, input logic tk);
        id_idata        = id;
        ex_idata        = ex;
        ex_regwrite     = rw;
        ex_memtoreg     = mtr;
        ex_branch_taken = tk;
    endtask

    // Advance one clock; the model consumes the same inputs the DUT saw.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!reset) m_step();
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] id;
        logic [31:0] ex;
        logic        rw;
        logic        mtr;
        logic        tk;
        logic [7:0]  ctl;
        int          cnt;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] id, input logic [31:0] ex,
                                input logic rw, input logic mtr, input logic tk,
                                input logic [7:0] ctl, input int cnt);
        vec_t v;
        v.id = id; v.ex = ex; v.rw = rw; v.mtr = mtr; v.tk = tk;
        v.ctl = ctl; v.cnt = cnt;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // ctl = {pc_hold, ifid_hold, ifid_flush, idex_bubble, fwd_a, fwd_b}
`ifdef HAZARD_FWD_EN
        tbl.push_back(mk(enc_r(6,5,7), enc_lw(5,1),     1,1,0, 8'hD0, 0)); // load-use
        tbl.push_back(mk(enc_r(6,5,7), NOP_INSTR,       0,0,0, 8'h00, 1)); // stall cleared
        tbl.push_back(mk(enc_r(4,3,3), enc_r(6,5,7),    1,0,0, 8'h08, 1)); // x5 from wb
        tbl.push_back(mk(NOP_INSTR,    enc_r(3,6,0),    1,0,0, 8'h04, 1)); // x6 from mem
        tbl.push_back(mk(NOP_INSTR,    enc_r(3,3,3),    1,0,0, 8'h05, 1)); // x3 from mem
        tbl.push_back(mk(NOP_INSTR,    enc_r(3,0,0),    1,0,0, 8'h00, 1));
        tbl.push_back(mk(NOP_INSTR,    enc_r(7,3,3),    1,0,0, 8'h05, 1)); // mem beats wb
        tbl.push_back(mk(NOP_INSTR,    enc_r(0,1,1),    1,0,0, 8'h00, 1));
        tbl.push_back(mk(NOP_INSTR,    enc_r(8,0,0),    1,0,0, 8'h00, 1)); // x0 never forwarded
        tbl.push_back(mk(enc_r(6,0,0), enc_lw(0,1),     1,1,0, 8'h00, 1)); // load to x0
        tbl.push_back(mk(enc_r(6,5,7), enc_lw(5,1),     1,1,1, 8'h30, 1)); // branch beats load-use
        tbl.push_back(mk(NOP_INSTR,    NOP_INSTR,       0,0,1, 8'h30, 1)); // flush 2, taken ignored
        tbl.push_back(mk(NOP_INSTR,    NOP_INSTR,       0,0,0, 8'h00, 1)); // back in RUN
        tbl.push_back(mk(enc_r(6,0,5), enc_lw(5,1),     1,1,0, 8'hD0, 1)); // rs2 load-use
        tbl.push_back(mk(enc_r(6,0,5), NOP_INSTR,       0,0,0, 8'h00, 2));
`else
        tbl.push_back(mk(enc_r(6,5,7), enc_lw(5,1),     1,1,0, 8'hD0, 0)); // ex writer
        tbl.push_back(mk(enc_r(6,5,7), NOP_INSTR,       0,0,0, 8'hD0, 1)); // mem writer
        tbl.push_back(mk(enc_r(6,5,7), NOP_INSTR,       0,0,0, 8'hD0, 2)); // wb writer
        tbl.push_back(mk(enc_r(6,5,7), NOP_INSTR,       0,0,0, 8'h00, 3));
        tbl.push_back(mk(enc_r(4,3,1), enc_r(3,1,2),    1,0,0, 8'hD0, 3)); // add x3 -> add x4,x3,x1
        tbl.push_back(mk(enc_r(4,3,1), NOP_INSTR,       0,0,0, 8'hD0, 4));
        tbl.push_back(mk(enc_r(4,3,1), NOP_INSTR,       0,0,0, 8'hD0, 5));
        tbl.push_back(mk(enc_r(4,3,1), NOP_INSTR,       0,0,0, 8'h00, 6));
        tbl.push_back(mk(enc_r(4,0,0), enc_r(0,1,1),    1,0,0, 8'h00, 6)); // x0 writer
        tbl.push_back(mk(enc_r(6,5,5), enc_r(5,0,0),    1,0,1, 8'h30, 6)); // branch beats interlock
        tbl.push_back(mk(enc_r(6,5,5), NOP_INSTR,       0,0,1, 8'h30, 6)); // flush 2, taken ignored
        tbl.push_back(mk(enc_r(6,5,5), NOP_INSTR,       0,0,0, 8'hD0, 6)); // RUN, wb x5 pending
        tbl.push_back(mk(enc_r(6,5,5), NOP_INSTR,       0,0,0, 8'h00, 7));
`endif

        // ---- reset state ----
        reset = 1'b1;
        apply(NOP_INSTR, NOP_INSTR, 1'b0, 1'b0, 1'b0);
        m_reset();
        #3;
        check("reset_ctl", 32'(ctl_vec), 32'h0);
        check("reset_cnt", 32'(stall_count), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_reset();

        // ---- directed table ----
        foreach (tbl[i]) begin
            apply(tbl[i].id, tbl[i].ex, tbl[i].rw, tbl[i].mtr, tbl[i].tk);
            #1;
            check($sformatf("vec%0d_ctl", i), 32'(ctl_vec), 32'(tbl[i].ctl));
            check($sformatf("vec%0d_cnt", i), 32'(stall_count), 32'(tbl[i].cnt));
            tick();
        end

        // ---- reset in the second flush cycle ----
        apply(NOP_INSTR, enc_r(5,0,0), 1'b1, 1'b0, 1'b1);
        #1;
        check("br_flush1", 32'(ctl_vec), 32'h30);
        tick();
        apply(NOP_INSTR, NOP_INSTR, 1'b0, 1'b0, 1'b0);
        #1;
        check("br_flush2", 32'(ctl_vec), 32'h30);
        #1;
        reset = 1'b1;
        apply(enc_r(6,5,7), enc_lw(5,1), 1'b1, 1'b1, 1'b1);
        #1;
        check("rst_async_ctl", 32'(ctl_vec), 32'h0);
        check("rst_async_cnt", 32'(stall_count), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        apply(NOP_INSTR, NOP_INSTR, 1'b0, 1'b0, 1'b0);
        #1;
        check("rst_no_flush", 32'(ctl_vec), 32'h0);
        tick();
        apply(enc_r(6,5,7), enc_lw(5,1), 1'b1, 1'b1, 1'b0);
        #1;
        check("rst_run_stall", 32'(ctl_vec), 32'hD0);
        tick();

        // ---- randomized run against the reference model ----
        for (int i = 0; i < 600; i++) begin
            apply(enc_r($urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,3)),
                  enc_r($urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,3)),
                  1'(($urandom % 4) != 0), 1'($urandom % 2), 1'(($urandom % 8) == 0));
            #1;
            check($sformatf("rnd%0d_ctl", i), 32'(ctl_vec), 32'(m_ctl()));
            check($sformatf("rnd%0d_cnt", i), 32'(stall_count), 32'(m_cnt));
            tick();
        end
        check("sat_cnt", 32'(stall_count), 32'(m_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_hazard_unit.md
# ex_hazard_unit

Hazard and forwarding controller at the consuming end of the decode-to-execute pipeline register. It reads the execute-stage fields that register presents, along with the instruction currently in decode. From these it drives stall, bubble, flush and operand-forwarding controls back into the fetch, decode and execute stages. It keeps its own shadow of the memory and writeback destinations, so no later pipeline register needs widening.

## Interface
- FLUSH_DEPTH, 2: cycles of squash after a taken branch (1..3).
- CNT_W, 16: width of the saturating stall counter.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- id_idata  in  32  instruction in decode; rs1=[19:15], rs2=[24:20].
- ex_idata  in  32  instruction in execute; rd=[11:7].
- ex_regwrite  in  1  execute instruction writes rd.
- ex_memtoreg  in  1  execute instruction is a load.
- ex_branch_taken  in  1  branch or jump resolved taken in execute this cycle.
- pc_hold  out  1  PC keeps its value.
- ifid_hold  out  1  fetch/decode register keeps its value.
- ifid_flush  out  1  fetch/decode register loads a NOP (0x00000013).
- idex_bubble  out  1  decode/execute register control inputs are forced to 0.
- fwd_a, fwd_b  out  2  operand select: 00 register file, 01 memory stage, 10 writeback stage.
- stall_count  out  CNT_W  load-use stall cycles since reset, saturating.

## Operation
- Shadow scoreboard:
  - Every cycle, mem_{rd,regwrite,memtoreg} <= ex fields and wb_{rd,regwrite} <= mem fields.
  - The shift continues during stalls, because execute always advances.
- FSM states: RUN, FLUSH.
  - RUN, ex_branch_taken=1: go to FLUSH with flush_cnt=FLUSH_DEPTH-1. The same cycle asserts ifid_flush and idex_bubble.
  - FLUSH: asserts ifid_flush and idex_bubble. flush_cnt decrements; return to RUN when flush_cnt=0. If FLUSH_DEPTH=1, go straight back to RUN.
  - ex_branch_taken while in FLUSH is ignored, since the execute stage then holds a bubble.
- Load-use hazard:
  - Condition: ex_memtoreg & ex_regwrite & rd!=0 & (rd==rs1 | rd==rs2).
  - Effect: pc_hold=ifid_hold=idex_bubble=1 for that cycle.
  - Evaluated combinationally in RUN only.
- Priority: flush (RUN+taken, or FLUSH) overrides load-use. With flush active, pc_hold=ifid_hold=0.
- Forwarding per operand:
  - 01 if mem_regwrite & mem_rd!=0 & mem_rd==ex rs.
  - Otherwise 10 if wb_regwrite & wb_rd!=0 & wb_rd==ex rs.
  - Otherwise 00. The memory stage wins when both match.
  - Execute rs1/rs2 are taken from ex_idata.
- x0 is never a hazard or a forwarding source.
- stall_count increments on each load-use stall cycle and saturates at all-ones.

## Timing
- Hold, flush, bubble and fwd outputs are combinational from inputs and current state. Zero latency: they take effect at the next edge.
- A load-use stall lasts exactly 1 cycle: the next cycle, execute holds a bubble, so the condition clears.
- A taken branch produces exactly FLUSH_DEPTH cycles of ifid_flush/idex_bubble, counting the resolving cycle.
- The scoreboard lags execute by exactly 1 (mem) and 2 (wb) cycles.
- Reset values, immediate on reset assertion:
  - State: FSM=RUN, scoreboard all 0, stall_count=0.
  - Outputs: fwd_a=fwd_b=00, hold/flush/bubble=0.
- Reset mid-flush aborts the flush. The first edge after deassertion runs in RUN.

## Configuration
- HAZARD_FWD_EN defined: forwarding as above. Only load-use stalls.
- HAZARD_FWD_EN undefined:
  - fwd_a=fwd_b=00 constantly.
  - Full interlock: stall in RUN whenever any pending writer (ex, mem or wb) with rd!=0 matches a decode rs1/rs2.
  - Stall persists until no match. stall_count counts these cycles.

## Structure
- Shared package holds:
  - FWD_RF/FWD_MEM/FWD_WB encodings.
  - FSM state enum.
  - NOP constant 0x00000013.
  - rs1/rs2/rd field bit positions.
- One sub-module, hazard_fwd_sel: combinational per-operand forward select, instantiated twice.

## Test plan
- Load-use: ex_idata=lw x5 (memtoreg=1, regwrite=1); id_idata=add x6,x5,x7 -> pc_hold=ifid_hold=idex_bubble=1 for 1 cycle, stall_count=1.
- Mem-stage forwarding: add x3 writes x3, next ex_idata=sub x4,x3,x3 -> fwd_a=fwd_b=01.
- Priority and x0: x3 written two cycles earlier and x3 written one cycle earlier -> fwd=01. Writes to x0 -> fwd=00.
- Taken branch with FLUSH_DEPTH=2 -> ifid_flush=idex_bubble=1 for exactly 2 cycles. A load-use condition in the same cycle yields pc_hold=0.
- Reset asserted in the second flush cycle -> all outputs 0 asynchronously; the next instruction is not flushed.
- HAZARD_FWD_EN undefined: add x3 then add x4,x3,x1 -> 3 stall cycles, fwd=00 throughout.
